flush_req_gen: RTL
==================

Name: flush_req_gen

Overview:
- Producer side of the pipeline flush handshake.
- Generates the free-running `cycle_cnt` phase counter and the 2-bit `flush` code that the flush-stall controller samples when `cycle_cnt == 4`.
- Accepts single-cycle flush requests from the execute/trap logic, buffers one, and holds each flush code across the required number of sample windows.
- Sits in the core control path between EXU redirect/trap sources and the flush-stall controller.

Parameters:
- CNT_W, 4, width of `cycle_cnt`.
- CYCLE_MAX, 7, terminal count; `cycle_cnt` wraps CYCLE_MAX -> 0.
- SAMPLE_CNT, 4, phase at which the consumer samples `flush`; must be <= CYCLE_MAX.
- HOLD_W, 4, width of `req_len` and the internal hold counter.
- EVT_W, 8, width of `flush_events`.

Ports:
- hclk  in  1  clock.
- hrstn  in  1  asynchronous active-low reset.
- req_flush1  in  1  pulse: request a single-window flush (code 1).
- req_flush2  in  1  pulse: request an extended flush (code 2).
- req_len  in  HOLD_W  extra sample windows to hold code 2; sampled together with `req_flush2`.
- cycle_cnt  out  CNT_W  phase counter.
- flush  out  2  0 = disable, 1 = cycle-1 flush, 2 = cycle-2 flush.
- req_ready  out  1  pending slot empty.
- busy  out  1  FSM not IDLE or pending slot valid.
- dropped  out  1  one-cycle pulse when a request is discarded.
- flush_events  out  EVT_W  saturating count of completed flushes.

Behaviour:
- Reset (`hrstn` low, async):
  - `cycle_cnt` = 0, state = IDLE, `flush` = 0.
  - Pending slot cleared, hold counter = 0, `dropped` = 0, `flush_events` = 0.
  - Takes effect immediately, including mid-flush; `flush` returns to 0 without completing the hold.
- Counter:
  - `cycle_cnt` increments every cycle and wraps CYCLE_MAX -> 0.
  - `sample_pt` = (`cycle_cnt` == SAMPLE_CNT), combinational.
- Pending slot (one deep: `pend_valid`, `pend_kind`, `pend_len`), updated on `hclk` rising edge:
  - `req_flush2` asserted: if the slot is empty or holds kind 1, load kind 2 with `req_len`. An overwritten kind-1 entry is an upgrade, not a drop.
  - `req_flush2` while the slot holds kind 2: the request is dropped and `dropped` = 1 next cycle.
  - `req_flush1` asserted with `req_flush2` low: load kind 1 if the slot is empty. If the slot is full, drop it and pulse `dropped`.
  - `req_flush1` and `req_flush2` together: kind 2 wins. The kind-1 request is dropped and `dropped` pulses.
  - `req_ready` = !`pend_valid`.
- FSM states: IDLE (code 0), ARM1 (code 1), ARM2 (code 2). `flush` = state code, a direct register decode.
  - IDLE: if `pend_valid`, go to ARM1 or ARM2 per `pend_kind`, load the hold counter with `pend_len`, and clear `pend_valid`. A request arriving in the same cycle refills the slot.
  - ARM1: hold. On `sample_pt`, go to IDLE and increment `flush_events`.
  - ARM2: hold. On `sample_pt`:
    - hold counter == 0: go to IDLE and increment `flush_events`.
    - otherwise: decrement the hold counter and stay in ARM2.
  - The FSM always returns to IDLE for at least one cycle between flushes.
- Latency: a request pulse in cycle t gives `flush` != 0 from cycle t+2, when the slot was empty and the FSM was IDLE.
  - Code 1 is presented to exactly one `sample_pt`.
  - Code 2 is presented to exactly `req_len` + 1 consecutive `sample_pt` cycles.
- `busy` = (state != IDLE) || `pend_valid`.
- `flush_events` saturates at all-ones and does not wrap.

Test Plan:
- Reset with no requests -> `cycle_cnt` sequence 0,1,…,7,0,1 is continuous; `flush` = 0 throughout; `busy` = 0.
- `req_flush1` pulsed at `cycle_cnt` = 1 -> `flush` = 1 while `cycle_cnt` = 3,4; `flush` = 0 at `cycle_cnt` = 5; `flush_events` = 1.
- `req_flush2` with `req_len` = 1 pulsed at `cycle_cnt` = 6 -> `flush` = 2 from `cycle_cnt` = 0 (after wrap) through the second subsequent `cycle_cnt` = 4, then 0; `flush_events` = 1.
- `req_flush1` and `req_flush2` (`req_len` = 0) in the same cycle -> `dropped` pulses once; one flush with code 2 for a single window; no code-1 flush follows.
- `req_flush1`, then `req_flush2` one cycle later before the FSM leaves IDLE -> slot upgrade; a single code-2 flush; `dropped` never asserts.
- `hrstn` driven low while in ARM2 with the hold counter at 3 -> `flush` = 0 and `cycle_cnt` = 0 immediately, without waiting for a clock edge; after release, the counter restarts from 0 and `busy` = 0.

Source files
------------

// File: rtl/flush_req_gen_if.sv
// Flush request / flush code bundle between the EXU-side requester and the
// flush request generator.
interface flush_req_gen_if #(
    parameter int CNT_W  = 4,
    parameter int HOLD_W = 4,
    parameter int EVT_W  = 8
);
    logic              req_flush1;
    logic              req_flush2;
    logic [HOLD_W-1:0] req_len;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [1:0]        flush;
    logic              req_ready;
    logic              busy;
    logic              dropped;
    logic [EVT_W-1:0]  flush_events;

    modport master (
        output req_flush1, req_flush2, req_len,
        input  cycle_cnt, flush, req_ready, busy, dropped, flush_events
    );

    modport slave (
        input  req_flush1, req_flush2, req_len,
        output cycle_cnt, flush, req_ready, busy, dropped, flush_events
    );
endinterface

// File: rtl/flush_req_gen.sv
// Producer side of the pipeline flush handshake: phase counter, one-deep
// request slot and the flush-code FSM sampled by the flush-stall controller.
//
// state | meaning
// IDLE  | flush = 0, waiting for a pending request
// ARM1  | flush = 1, held until the next sample point
// ARM2  | flush = 2, held for hold counter + 1 sample points
module flush_req_gen #(
    parameter int CNT_W      = 4,
    parameter int CYCLE_MAX  = 7,
    parameter int SAMPLE_CNT = 4,
    parameter int HOLD_W     = 4,
    parameter int EVT_W      = 8
) (
    input logic            hclk,
    input logic            hrstn,
    flush_req_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM1 = 2'd1,
        ARM2 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CYCLE_MAX);
    localparam logic [CNT_W-1:0] CNT_SMPL = CNT_W'(SAMPLE_CNT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              pend_valid_q, pend_valid_d;
    logic              pend_kind2_q, pend_kind2_d;
    logic [HOLD_W-1:0] pend_len_q, pend_len_d;
    logic              drop_q, drop_d;
    logic [EVT_W-1:0]  evt_q, evt_d;
    logic              sample_pt;
    logic              complete;
    logic              merge;

    assign sample_pt = (cnt_q == CNT_SMPL);

    always_comb begin
        cnt_d        = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        state_d      = state_q;
        hold_d       = hold_q;
        pend_valid_d = pend_valid_q;
        pend_kind2_d = pend_kind2_q;
        pend_len_d   = pend_len_q;
        drop_d       = 1'b0;
        evt_d        = evt_q;
        complete     = 1'b0;
        merge        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    // A code-2 request landing on a queued code-1 upgrades it in place.
                    if (bus.req_flush2 && !pend_kind2_q) begin
                        merge   = 1'b1;
                        state_d = ARM2;
                        hold_d  = bus.req_len;
                    end else begin
                        state_d = pend_kind2_q ? ARM2 : ARM1;
                        hold_d  = pend_len_q;
                    end
                    pend_valid_d = 1'b0;
                end
            end
            ARM1: begin
                if (sample_pt) begin
                    state_d  = IDLE;
                    complete = 1'b1;
                end
            end
            ARM2: begin
                if (sample_pt) begin
                    if (hold_q == '0) begin
                        state_d  = IDLE;
                        complete = 1'b1;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete && (evt_q != '1)) begin
            evt_d = evt_q + EVT_W'(1);
        end

        // Slot occupancy seen by new requests is after any dispatch this cycle.
        if (bus.req_flush2) begin
            if (bus.req_flush1) begin
                drop_d = 1'b1;
            end
            if (!merge) begin
                if (pend_valid_d && pend_kind2_d) begin
                    drop_d = 1'b1;
                end else begin
                    pend_valid_d = 1'b1;
                    pend_kind2_d = 1'b1;
                    pend_len_d   = bus.req_len;
                end
            end
        end else if (bus.req_flush1) begin
            if (pend_valid_d) begin
                drop_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_kind2_d = 1'b0;
                pend_len_d   = '0;
            end
        end
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hold_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_kind2_q <= 1'b0;
            pend_len_q   <= '0;
            drop_q       <= 1'b0;
            evt_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            pend_valid_q <= pend_valid_d;
            pend_kind2_q <= pend_kind2_d;
            pend_len_q   <= pend_len_d;
            drop_q       <= drop_d;
            evt_q        <= evt_d;
        end
    end

    assign bus.cycle_cnt    = cnt_q;
    assign bus.flush        = state_q;
    assign bus.req_ready    = !pend_valid_q;
    assign bus.busy         = (state_q != IDLE) || pend_valid_q;
    assign bus.dropped      = drop_q;
    assign bus.flush_events = evt_q;
endmodule
